// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by index.
// Optional INV_CIPHER_FASTPATH_EN lets a new block be accepted on the output handshake edge.
module inv_cipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    state_e         state_q;
    logic   [3:0]   rnd_q;
    logic   [127:0] data_q;
    logic   [127:0] data_d;
    logic   [127:0] shifted;
    logic   [127:0] subbed;
    logic   [127:0] addKey;
    logic   [127:0] mixed;

    function automatic logic [7:0] invSbox(input logic [7:0] b);
        return INV_SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[8*(15-(r+4*((c+r)%4))) +: 8] = data_q[8*(15-(r+4*c)) +: 8];
            end
        end
    end

    always_comb begin
        subbed = '0;
        for (int n = 0; n < 16; n++) begin
            subbed[8*n +: 8] = invSbox(shifted[8*n +: 8]);
        end
    end

    assign addKey = subbed ^ rk_data;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = invMixCol(addKey[127-32*c -: 32]);
        end
    end

    // The last round (rnd 0) skips InvMixColumns.
    assign data_d = (rnd_q == 4'd0) ? addKey : mixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data ^ rk_data;
                        rnd_q   <= 4'd9;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    data_q <= data_d;
                    if (rnd_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
`ifdef INV_CIPHER_FASTPATH_EN
                        if (in_valid) begin
                            data_q  <= in_data ^ rk_data;
                            rnd_q   <= 4'd9;
                            state_q <= ROUND;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_idx    = (state_q == ROUND) ? rnd_q : 4'd10;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

`ifdef INV_CIPHER_FASTPATH_EN
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

endmodule

// File: tb/tb_inv_cipher.sv
// Self-checking bench for inv_cipher: known FIPS-197 vectors plus random blocks
// whose ciphertext comes from a forward-cipher reference model.
`timescale 1ns/1ps
module tb_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;
    int keySel = 0;

    logic [7:0]   sboxT [256];
    logic [127:0] rkSet [2][11];

`ifdef INV_CIPHER_FASTPATH_EN
    localparam int BLOCK_PERIOD = 11;
`else
    localparam int BLOCK_PERIOD = 12;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    inv_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Combinational key store.
    assign rk_data = (rk_idx <= 4'd10) ? rkSet[keySel][rk_idx] : '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from multiplicative inverse plus affine transform.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxT[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic loadKeys(input logic [127:0] key, input int set);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkSet[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encryptRef(input logic [127:0] pt, input int set);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        logic [127:0] k;
        k = rkSet[set][0];
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ k[127-8*n -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int n = 0; n < 16; n++) s[n] = sboxT[s[n]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = s[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int n = 0; n < 16; n++) s[n] = t[n];
            end
            k = rkSet[set][rd];
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Decrypts one block from IDLE; holds out_ready low for 'hold' cycles in DONE,
    // pulsing in_valid once in the middle of that window when hold > 0.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt,
                                 input string tag, input int hold);
        int lat;
        checkOutput({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
        checkOutput({tag, " rk_idx accept"}, 128'(rk_idx), 128'd10);
        in_data   = ct;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            if (lat <= 10) checkOutput({tag, " rk_idx seq"}, 128'(rk_idx), 128'(10 - lat));
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 128'(lat), 128'd11);
        checkOutput({tag, " plaintext"}, out_data, pt);
        for (int i = 0; i < hold; i++) begin
            checkOutput({tag, " hold out_valid"}, 128'(out_valid), 128'd1);
            checkOutput({tag, " hold in_ready"}, 128'(in_ready), 128'd0);
            checkOutput({tag, " hold out_data"}, out_data, pt);
            if (i == hold / 2) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after hs"}, 128'(out_valid), 128'd0);
        checkOutput({tag, " in_ready after hs"}, 128'(in_ready), 128'd1);
    endtask

    task automatic backToBack();
        int accepted;
        int nOut;
        int outCyc [2];
        logic [127:0] outDat [2];
        logic willAccept;
        outCyc[0] = 0; outCyc[1] = 0;
        outDat[0] = '0; outDat[1] = '0;
        accepted  = 0;
        nOut      = 0;
        keySel    = 0;
        in_data   = C1_CT;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && nOut < 2; k++) begin
            willAccept = in_valid && in_ready;
            if (out_valid) begin
                outCyc[nOut] = cyc;
                outDat[nOut] = out_data;
                nOut++;
                keySel = 1;
            end
            @(posedge clk); #1;
            if (willAccept) begin
                accepted++;
                if (accepted == 1) in_data = B_CT;
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b outputs seen", 128'(nOut), 128'd2);
        checkOutput("b2b spacing", 128'(outCyc[1] - outCyc[0]), 128'(BLOCK_PERIOD));
        checkOutput("b2b first pt", outDat[0], C1_PT);
        checkOutput("b2b second pt", outDat[1], B_PT);
        checkOutput("b2b idle after", 128'(in_ready), 128'd1);
        keySel = 0;
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        buildSbox();

        #2;
        checkOutput("reset in_ready", 128'(in_ready), 128'd1);
        checkOutput("reset rk_idx", 128'(rk_idx), 128'd10);
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset out_data", out_data, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        loadKeys(C1_KEY, 0);
        loadKeys(B_KEY, 1);
        keySel = 0;
        applyStimulus(C1_CT, C1_PT, "C1", 0);
        keySel = 1;
        applyStimulus(B_CT, B_PT, "AppB", 0);
        keySel = 0;
        applyStimulus(C1_CT, C1_PT, "backpressure", 20);

        in_data  = C1_CT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst round5", 128'(rk_idx), 128'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out_valid", 128'(out_valid), 128'd0);
        checkOutput("midrst in_ready", 128'(in_ready), 128'd1);
        checkOutput("midrst rk_idx", 128'(rk_idx), 128'd10);
        checkOutput("midrst out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(C1_CT, C1_PT, "C1 after reset", 0);

        backToBack();

        for (int i = 0; i < 8; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            loadKeys(key, 0);
            keySel = 0;
            applyStimulus(encryptRef(pt, 0), pt, "random", int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
